// File: rtl/ssem_pkg.sv
// Shared encodings for the SSEM beat controller: beat codes, opcodes and CI actions.
package ssem_pkg;

  typedef enum logic [2:0] {
    BeatHalt    = 3'd0,
    BeatScan1   = 3'd1,
    BeatAction1 = 3'd2,
    BeatScan2   = 3'd3,
    BeatAction2 = 3'd4
  } beat_e;

  typedef enum logic [1:0] {
    CiNone = 2'b00,
    CiInc  = 2'b01,
    CiAbs  = 2'b10,
    CiRel  = 2'b11
  } ci_op_e;

  localparam logic [2:0] OpJmp  = 3'b000;
  localparam logic [2:0] OpJrp  = 3'b001;
  localparam logic [2:0] OpLdn  = 3'b010;
  localparam logic [2:0] OpSto  = 3'b011;
  localparam logic [2:0] OpSub  = 3'b100;
  localparam logic [2:0] OpSub2 = 3'b101;
  localparam logic [2:0] OpCmp  = 3'b110;
  localparam logic [2:0] OpStp  = 3'b111;

endpackage

// File: rtl/beat_timer.sv
// Digit counter for one beat: counts 0..INSTR_BITS+FLYBACK_TIME-1 while running, holds 0 when idle.
module beat_timer #(
  parameter int unsigned INSTR_BITS   = 20,
  parameter int unsigned FLYBACK_TIME = 4,
  parameter int unsigned DIGIT_BITS   = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  run_i,
  output logic [DIGIT_BITS-1:0] digit_o,
  output logic                  wrap_o,
  output logic                  flyback_o
);

  localparam logic [DIGIT_BITS-1:0] LastDigit  = DIGIT_BITS'(INSTR_BITS + FLYBACK_TIME - 1);
  localparam logic [DIGIT_BITS-1:0] FirstFly   = DIGIT_BITS'(INSTR_BITS);

  logic [DIGIT_BITS-1:0] digit_q, digit_d;

  always_comb begin
    digit_d = digit_q;
    if (!run_i || digit_q == LastDigit) begin
      digit_d = '0;
    end else begin
      digit_d = digit_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit_o   = digit_q;
  assign wrap_o    = run_i && (digit_q == LastDigit);
  assign flyback_o = run_i && (digit_q >= FirstFly);

endmodule

// File: rtl/beat_controller.sv
// SSEM beat sequencer: HALT -> SCAN1 -> ACTION1 -> SCAN2 -> ACTION2, with opcode decode
// into CI, accumulator and store strobes.
module beat_controller
  import ssem_pkg::*;
#(
  parameter int unsigned INSTR_BITS   = 20,
  parameter int unsigned FLYBACK_TIME = 4,
  parameter int unsigned DIGIT_BITS   = 5
) (
  input  logic                  w_DPG,
  input  logic                  w_RESET_N,
  input  logic                  w_RUN,
  input  logic                  w_STEP,
  input  logic [2:0]            b_OPCODE,
  input  logic                  w_A_NEG,
  output logic [2:0]            b_BEAT,
  output logic [DIGIT_BITS-1:0] b_DIGIT,
  output logic                  w_FLYBACK,
  output logic                  w_ADDR_SEL,
  output logic                  w_PI_LOAD,
  output logic [1:0]            b_CI_OP,
  output logic                  w_CI_SKIP,
  output logic                  w_A_LDN,
  output logic                  w_A_SUB,
  output logic                  w_XTB,
  output logic                  w_STOPPED
);

  localparam logic [DIGIT_BITS-1:0] LastWord = DIGIT_BITS'(INSTR_BITS - 1);

  beat_e                 beat_q;
  logic [2:0]            opcode_q;
  logic                  skip_q;
  // Arm flags remember the input was low last cycle, so a level held through reset never starts.
  logic                  run_arm_q, step_arm_q;
  logic                  start;
  logic [DIGIT_BITS-1:0] digit;
  logic                  wrap, flyback;
  ci_op_e                ci_op;
  logic                  a_ldn, a_sub;

  beat_timer #(
    .INSTR_BITS  (INSTR_BITS),
    .FLYBACK_TIME(FLYBACK_TIME),
    .DIGIT_BITS  (DIGIT_BITS)
  ) u_beat_timer (
    .clk_i    (w_DPG),
    .rst_ni   (w_RESET_N),
    .run_i    (beat_q != BeatHalt),
    .digit_o  (digit),
    .wrap_o   (wrap),
    .flyback_o(flyback)
  );

  assign start = (w_RUN && run_arm_q) || (w_STEP && step_arm_q);

  always_ff @(posedge w_DPG or negedge w_RESET_N) begin
    if (!w_RESET_N) begin
      beat_q     <= BeatHalt;
      opcode_q   <= OpJmp;
      skip_q     <= 1'b0;
      run_arm_q  <= 1'b0;
      step_arm_q <= 1'b0;
    end else begin
      run_arm_q  <= ~w_RUN;
      step_arm_q <= ~w_STEP;
      unique case (beat_q)
        BeatHalt: begin
          if (start) beat_q <= BeatScan1;
        end
        BeatScan1: begin
          if (wrap) begin
            beat_q <= BeatAction1;
            skip_q <= 1'b0;
          end
        end
        BeatAction1: begin
          if (wrap) beat_q <= BeatScan2;
        end
        BeatScan2: begin
          if (digit == '0) opcode_q <= b_OPCODE;
          if (wrap) beat_q <= BeatAction2;
        end
        BeatAction2: begin
          // The sign digit is the last word digit of the accumulator.
          if (opcode_q == OpCmp && digit == LastWord) skip_q <= w_A_NEG;
          if (wrap) beat_q <= (opcode_q == OpStp || !w_RUN) ? BeatHalt : BeatScan1;
        end
        default: beat_q <= BeatHalt;
      endcase
    end
  end

  always_comb begin
    ci_op = CiNone;
    a_ldn = 1'b0;
    a_sub = 1'b0;
    if (beat_q == BeatScan1 && !flyback) begin
      ci_op = CiInc;
    end else if (beat_q == BeatAction2 && !flyback) begin
      case (opcode_q)
        OpJmp:         ci_op = CiAbs;
        OpJrp:         ci_op = CiRel;
        OpLdn:         a_ldn = 1'b1;
        OpSub, OpSub2: a_sub = 1'b1;
        default:       ;
      endcase
    end
  end

  assign b_BEAT     = beat_q;
  assign b_DIGIT    = digit;
  assign w_FLYBACK  = flyback;
  assign w_ADDR_SEL = (beat_q == BeatAction2);
  assign w_PI_LOAD  = (beat_q == BeatAction1) && wrap;
  assign b_CI_OP    = ci_op;
  assign w_CI_SKIP  = (beat_q == BeatScan1) && !flyback && skip_q;
  assign w_A_LDN    = a_ldn;
  assign w_A_SUB    = a_sub;
  assign w_XTB      = (beat_q == BeatAction2) && wrap && (opcode_q == OpSto);
  assign w_STOPPED  = (beat_q == BeatHalt);

endmodule

// File: doc/beat_controller.md
BEAT_CONTROLLER -- requirements
Module: beat_controller

Interface
REQ-001 SHALL have parameter INSTR_BITS, default 20: word length in digits.
REQ-002 SHALL have parameter FLYBACK_TIME, default 4: flyback digits per beat.
REQ-003 SHALL have parameter DIGIT_BITS, default 5: width of the digit counter, equal to ceil(log2(INSTR_BITS+FLYBACK_TIME)).
REQ-004 SHALL have port w_DPG  in  1  digit-pulse clock; all state changes on its rising edge.
REQ-005 SHALL have port w_RESET_N  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port w_RUN  in  1  run switch; a rising edge starts free-running; low means halt after the current instruction.
REQ-007 SHALL have port w_STEP  in  1  single-shot; a rising edge in HALT executes exactly one instruction.
REQ-008 SHALL have port b_OPCODE  in  3  function bits from the present-instruction latch.
REQ-009 SHALL have port w_A_NEG  in  1  serial accumulator digit, sampled as the sign at digit INSTR_BITS-1.
REQ-010 SHALL have port b_BEAT  out  3  state code: HALT=0, SCAN1=1, ACTION1=2, SCAN2=3, ACTION2=4.
REQ-011 SHALL have port b_DIGIT  out  DIGIT_BITS  current digit, 0..INSTR_BITS+FLYBACK_TIME-1.
REQ-012 SHALL have port w_FLYBACK  out  1  high while digit >= INSTR_BITS in a non-HALT state.
REQ-013 SHALL have port w_ADDR_SEL  out  1  store address source: 0 selects CI line, 1 selects operand line.
REQ-014 SHALL have port w_PI_LOAD  out  1  one-cycle strobe that latches the fetched instruction.
REQ-015 SHALL have port b_CI_OP  out  2  CI action: 00 none, 01 increment, 10 load absolute, 11 load relative.
REQ-016 SHALL have port w_CI_SKIP  out  1  qualifies an increment as +2.
REQ-017 SHALL have port w_A_LDN  out  1  load negated word into accumulator.
REQ-018 SHALL have port w_A_SUB  out  1  subtract word from accumulator.
REQ-019 SHALL have port w_XTB  out  1  one-cycle store write strobe.
REQ-020 SHALL have port w_STOPPED  out  1  stop lamp; high in HALT.

Function
REQ-021 SHALL define a beat as INSTR_BITS+FLYBACK_TIME cycles: digit counts 0..max, then wraps to 0 and the state advances.
REQ-022 SHALL hold digit at 0 in HALT.
REQ-023 SHALL leave HALT for SCAN1 with digit 0 on the cycle after a detected rising edge of w_RUN or w_STEP; w_RUN held high without an edge SHALL NOT restart.
REQ-024 SHALL sequence SCAN1 -> ACTION1 -> SCAN2 -> ACTION2, each transition at digit wrap.
REQ-025 SHALL, on ACTION2 wrap, go to HALT if the latched opcode is 111 (STP) or w_RUN is low, otherwise go to SCAN1; STP SHALL win over w_RUN.
REQ-026 SHALL ignore w_STEP edges outside HALT.
REQ-027 SHALL in SCAN1 drive b_CI_OP=01 for digits 0..INSTR_BITS-1, with w_ADDR_SEL=0 and w_CI_SKIP equal to the skip flag.
REQ-028 SHALL in ACTION1 drive w_ADDR_SEL=0 and pulse w_PI_LOAD at the last digit.
REQ-029 SHALL capture b_OPCODE into the opcode register on the first cycle of SCAN2.
REQ-030 SHALL in ACTION2 drive w_ADDR_SEL=1 and, during digits 0..INSTR_BITS-1 only, decode the latched opcode as follows: 000 -> b_CI_OP=10; 001 -> b_CI_OP=11; 010 -> w_A_LDN; 100 or 101 -> w_A_SUB; 011 -> w_XTB as a single pulse at the last flyback digit.
REQ-031 SHALL, for opcode 110 (CMP), set the skip flag to w_A_NEG at ACTION2 digit INSTR_BITS-1.
REQ-032 SHALL clear the skip flag at the SCAN1 wrap.
REQ-033 SHALL drive all strobes and enables low in HALT and during flyback, except the w_PI_LOAD and w_XTB pulses.
REQ-034 SHALL decode all outputs only from registered state, digit, opcode and skip flag, with no combinational input-to-output path.

Reset
REQ-035 SHALL, while w_RESET_N is low and regardless of beat, force HALT, digit=0, opcode=000, skip=0, edge detectors cleared, w_STOPPED=1 and all other outputs 0.
REQ-036 SHALL, after reset release, require a fresh w_RUN or w_STEP rising edge to start.

Structure
REQ-037 SHALL place beat codes, opcode constants and CI_OP encodings in a shared package, ssem_pkg.
REQ-038 SHALL place digit counting and flyback detection in a sub-module named beat_timer; state and opcode decode SHALL remain in beat_controller.

Verification
REQ-039 SHALL verify STEP with latched opcode 010: one pulse -> SCAN1..ACTION2 takes exactly 96 cycles, w_A_LDN is high for 20 cycles, then the block returns to HALT with w_STOPPED=1.
REQ-040 SHALL verify RUN free-run with opcode 011: w_XTB pulses once per instruction at ACTION2 digit 23, at a 96-cycle period.
REQ-041 SHALL verify CMP with w_A_NEG=1 at digit 19: the next SCAN1 has b_CI_OP=01 and w_CI_SKIP=1; with w_A_NEG=0, w_CI_SKIP=0.
REQ-042 SHALL verify STP with w_RUN held high: HALT after ACTION2 and no restart until w_RUN toggles low then high.
REQ-043 SHALL verify w_RUN dropped during SCAN2: the instruction completes and HALT is entered at ACTION2 wrap.
REQ-044 SHALL verify reset asserted at ACTION2 digit 10: all outputs reset immediately, and the block stays in HALT after release.
